// File: rtl/pw_trigger_pkg.sv
// Shared definitions for the trigger pulse generator: FSM encoding and default sizes.
// Optional missed-match counter is enabled by defining PW_TRIG_MISSED_COUNT_EN.
package pw_trigger_pkg;

    localparam int unsigned CNT_WIDTH_DEF  = 24;
    localparam int unsigned NUM_PULSES_DEF = 8;
    localparam int unsigned NUM_WIDTH_DEF  = 4;
    localparam int unsigned MISSED_WIDTH   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_PULSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/pw_trig_down_counter.sv
// Loadable down-counter that stops at zero; times both the delay and the width phases.
module pw_trig_down_counter
    import pw_trigger_pkg::*;
#(
    parameter int unsigned pCNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [pCNT_WIDTH-1:0] value,
    output logic                  zero_c
);

    logic [pCNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (!zero_c) begin
            count <= count - pCNT_WIDTH'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/pw_trigger_pulse_gen.sv
// Match-triggered sequence of up to pNUM_TRIGGER_PULSES delayed pulses.
// Define PW_TRIG_MISSED_COUNT_EN to implement O_missed_count; otherwise it reads 0.
module pw_trigger_pulse_gen
    import pw_trigger_pkg::*;
#(
    parameter int unsigned pNUM_TRIGGER_PULSES = NUM_PULSES_DEF,
    parameter int unsigned pNUM_TRIGGER_WIDTH  = NUM_WIDTH_DEF,
    parameter int unsigned pCNT_WIDTH          = CNT_WIDTH_DEF
) (
    input  logic                                      trigger_clk,
    input  logic                                      reset_n,
    input  logic                                      I_match,
    input  logic                                      I_trigger_enable,
    input  logic [pNUM_TRIGGER_WIDTH-1:0]             I_num_triggers,
    input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_delay,
    input  logic [pCNT_WIDTH*pNUM_TRIGGER_PULSES-1:0] I_trigger_width,
    output logic                                      O_trigger,
    output logic                                      O_busy,
    output logic                                      O_done,
    output logic [pNUM_TRIGGER_WIDTH-1:0]             O_pulse_index,
    output logic [MISSED_WIDTH-1:0]                   O_missed_count
);

    localparam int unsigned IW  = pNUM_TRIGGER_WIDTH;
    localparam int unsigned IW1 = pNUM_TRIGGER_WIDTH + 1;
    localparam int unsigned CW  = pCNT_WIDTH;
    localparam logic [IW-1:0] MAX_NUM = IW'(pNUM_TRIGGER_PULSES);

    state_t        state;
    state_t        nxt_state;
    logic [IW-1:0] nxt_idx;
    logic [IW-1:0] adv_idx;
    logic [IW-1:0] start_idx;
    logic [IW-1:0] num_c;
    logic [CW-1:0] start_delay;
    logic [CW-1:0] start_width;
    logic [CW-1:0] cur_width;
    logic [CW-1:0] cnt_value;
    logic          cnt_load;
    logic          cnt_zero;
    logic          more_pulses;
    logic          advance;

    function automatic logic [CW-1:0] pick(
        input logic [CW*pNUM_TRIGGER_PULSES-1:0] bus,
        input logic [IW-1:0]                     sel
    );
        pick = '0;
        for (int k = 0; k < int'(pNUM_TRIGGER_PULSES); k++) begin
            if (sel == IW'(k)) pick = bus[k*CW +: CW];
        end
    endfunction

    assign num_c       = (I_num_triggers > MAX_NUM) ? MAX_NUM : I_num_triggers;
    assign adv_idx     = O_pulse_index + IW'(1);
    assign start_idx   = (state == ST_IDLE) ? '0 : adv_idx;
    assign start_delay = pick(I_trigger_delay, start_idx);
    assign start_width = pick(I_trigger_width, start_idx);
    assign cur_width   = pick(I_trigger_width, O_pulse_index);
    assign more_pulses = ({1'b0, O_pulse_index} + IW1'(1)) < {1'b0, num_c};

    // Next-state and counter-load decisions; 'advance' begins pulse start_idx.
    always_comb begin
        nxt_state = state;
        nxt_idx   = O_pulse_index;
        cnt_load  = 1'b0;
        cnt_value = '0;
        advance   = 1'b0;
        if (state != ST_IDLE && !I_trigger_enable) begin
            nxt_state = ST_IDLE;
            cnt_load  = 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_match && I_trigger_enable) begin
                        if (num_c == '0) nxt_state = ST_DONE;
                        else             advance   = 1'b1;
                    end
                end
                ST_DELAY: begin
                    if (cnt_zero) begin
                        if (cur_width != '0) begin
                            nxt_state = ST_PULSE;
                            cnt_load  = 1'b1;
                            cnt_value = cur_width - CW'(1);
                        end else if (more_pulses) begin
                            advance = 1'b1;
                        end else begin
                            nxt_state = ST_DONE;
                        end
                    end
                end
                ST_PULSE: begin
                    if (cnt_zero) begin
                        if (more_pulses) advance   = 1'b1;
                        else             nxt_state = ST_DONE;
                    end
                end
                ST_DONE:  nxt_state = ST_IDLE;
                default:  nxt_state = ST_IDLE;
            endcase
        end
        if (advance) begin
            nxt_idx  = start_idx;
            cnt_load = 1'b1;
            if (start_delay != '0) begin
                nxt_state = ST_DELAY;
                cnt_value = start_delay - CW'(1);
            end else if (start_width != '0) begin
                nxt_state = ST_PULSE;
                cnt_value = start_width - CW'(1);
            end else begin
                // A pulse with zero delay and zero width still occupies one low cycle
                nxt_state = ST_DELAY;
            end
        end
    end

    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            O_trigger     <= 1'b0;
            O_busy        <= 1'b0;
            O_done        <= 1'b0;
            O_pulse_index <= '0;
        end else begin
            state         <= nxt_state;
            O_trigger     <= (nxt_state == ST_PULSE);
            O_busy        <= (nxt_state != ST_IDLE);
            O_done        <= (nxt_state == ST_DONE);
            O_pulse_index <= (nxt_state == ST_IDLE) ? '0 : nxt_idx;
        end
    end

    pw_trig_down_counter #(
        .pCNT_WIDTH(CW)
    ) u_counter (
        .clk    (trigger_clk),
        .rst_n  (reset_n),
        .load   (cnt_load),
        .value  (cnt_value),
        .zero_c (cnt_zero)
    );

`ifdef PW_TRIG_MISSED_COUNT_EN
    // Saturating count of matches seen while a sequence is in progress
    always_ff @(posedge trigger_clk or negedge reset_n) begin
        if (!reset_n) begin
            O_missed_count <= '0;
        end else if (I_match && O_busy && (O_missed_count != '1)) begin
            O_missed_count <= O_missed_count + MISSED_WIDTH'(1);
        end
    end
`else
    assign O_missed_count = '0;
`endif

endmodule

// File: tb/tb_pw_trigger_pulse_gen.sv
// Directed bench for pw_trigger_pulse_gen: a per-cycle vector table plus hand sequences.
module tb_pw_trigger_pulse_gen;

    localparam int unsigned CW = 24;
    localparam int unsigned NP = 8;
    localparam int unsigned NW = 4;
`ifdef PW_TRIG_MISSED_COUNT_EN
    localparam bit MISS_EN = 1'b1;
`else
    localparam bit MISS_EN = 1'b0;
`endif

    logic              trigger_clk = 1'b0;
    logic              reset_n;
    logic              I_match;
    logic              I_trigger_enable;
    logic [NW-1:0]     I_num_triggers;
    logic [CW*NP-1:0]  I_trigger_delay;
    logic [CW*NP-1:0]  I_trigger_width;
    logic              O_trigger;
    logic              O_busy;
    logic              O_done;
    logic [NW-1:0]     O_pulse_index;
    logic [7:0]        O_missed_count;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       m;
        logic       en;
        logic       t;
        logic       b;
        logic       d;
        logic [3:0] idx;
        logic [7:0] miss;
    } vec_t;

    vec_t tbl [19];

    pw_trigger_pulse_gen #(
        .pNUM_TRIGGER_PULSES(NP),
        .pNUM_TRIGGER_WIDTH (NW),
        .pCNT_WIDTH         (CW)
    ) dut (
        .trigger_clk      (trigger_clk),
        .reset_n          (reset_n),
        .I_match          (I_match),
        .I_trigger_enable (I_trigger_enable),
        .I_num_triggers   (I_num_triggers),
        .I_trigger_delay  (I_trigger_delay),
        .I_trigger_width  (I_trigger_width),
        .O_trigger        (O_trigger),
        .O_busy           (O_busy),
        .O_done           (O_done),
        .O_pulse_index    (O_pulse_index),
        .O_missed_count   (O_missed_count)
    );

    always #5 trigger_clk = ~trigger_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge trigger_clk);
        #1;
    endtask

    task automatic set_pulse(input int i, input logic [CW-1:0] d, input logic [CW-1:0] w);
        I_trigger_delay[i*CW +: CW] = d;
        I_trigger_width[i*CW +: CW] = w;
    endtask

    function automatic vec_t mk(input logic m, input logic en, input logic t, input logic b,
                                input logic d, input logic [3:0] idx, input logic [7:0] miss);
        vec_t v;
        v = '{m, en, t, b, d, idx, miss};
        return v;
    endfunction

    // Match at cycle 0, then observe cycles 1..ncyc
    task automatic run_seq(input int ncyc, output int high_cnt, output int first_high,
                           output int last_high, output int max_idx, output int done_at);
        high_cnt = 0; first_high = -1; last_high = -1; max_idx = 0; done_at = -1;
        tick();
        I_match = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            tick();
            I_match = 1'b0;
            if (O_trigger) begin
                high_cnt++;
                if (first_high < 0) first_high = c;
                last_high = c;
            end
            if (int'(O_pulse_index) > max_idx) max_idx = int'(O_pulse_index);
            if (O_done && done_at < 0) done_at = c;
        end
    endtask

    initial begin
        int hc, fh, lh, mi, da, dcnt;

        reset_n          = 1'b0;
        I_match          = 1'b0;
        I_trigger_enable = 1'b0;
        I_num_triggers   = '0;
        I_trigger_delay  = '0;
        I_trigger_width  = '0;

        // REQ-036 per-cycle table, extra matches at cycle 3 (busy) and 17 (DONE)
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 0, 1, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 0, 1, 0, 0, 1);
        tbl[5]  = mk(0, 1, 0, 1, 0, 0, 1);
        tbl[6]  = mk(0, 1, 1, 1, 0, 0, 1);
        tbl[7]  = mk(0, 1, 1, 1, 0, 0, 1);
        tbl[8]  = mk(0, 1, 1, 1, 0, 0, 1);
        tbl[9]  = mk(0, 1, 0, 1, 0, 1, 1);
        tbl[10] = mk(0, 1, 0, 1, 0, 1, 1);
        tbl[11] = mk(0, 1, 1, 1, 0, 1, 1);
        tbl[12] = mk(0, 1, 1, 1, 0, 1, 1);
        tbl[13] = mk(0, 1, 1, 1, 0, 1, 1);
        tbl[14] = mk(0, 1, 1, 1, 0, 1, 1);
        tbl[15] = mk(0, 1, 1, 1, 0, 2, 1);
        tbl[16] = mk(0, 1, 1, 1, 0, 2, 1);
        tbl[17] = mk(1, 1, 0, 1, 1, 2, 1);
        tbl[18] = mk(0, 1, 0, 0, 0, 0, 2);

        repeat (2) @(posedge trigger_clk);
        #1;
        check("reset trigger", 32'(O_trigger), 0);
        check("reset busy", 32'(O_busy), 0);
        check("reset done", 32'(O_done), 0);
        check("reset index", 32'(O_pulse_index), 0);
        check("reset missed", 32'(O_missed_count), 0);
        reset_n = 1'b1;
        I_trigger_enable = 1'b1;

        // REQ-035: single one-cycle pulse with no delay
        I_num_triggers = 4'd1;
        set_pulse(0, 0, 1);
        tick();
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        check("single T+1 trigger", 32'(O_trigger), 1);
        check("single T+1 busy", 32'(O_busy), 1);
        check("single T+1 done", 32'(O_done), 0);
        tick();
        check("single T+2 trigger", 32'(O_trigger), 0);
        check("single T+2 done", 32'(O_done), 1);
        tick();
        check("single T+3 busy", 32'(O_busy), 0);
        check("single T+3 done", 32'(O_done), 0);

        // REQ-036 table
        I_num_triggers = 4'd3;
        set_pulse(0, 5, 3);
        set_pulse(1, 2, 4);
        set_pulse(2, 0, 2);
        for (int i = 0; i < 19; i++) begin
            tick();
            check($sformatf("tbl[%0d] trigger", i), 32'(O_trigger), 32'(tbl[i].t));
            check($sformatf("tbl[%0d] busy", i), 32'(O_busy), 32'(tbl[i].b));
            check($sformatf("tbl[%0d] done", i), 32'(O_done), 32'(tbl[i].d));
            check($sformatf("tbl[%0d] index", i), 32'(O_pulse_index), 32'(tbl[i].idx));
            check($sformatf("tbl[%0d] missed", i), 32'(O_missed_count),
                  MISS_EN ? 32'(tbl[i].miss) : 32'd0);
            I_match          = tbl[i].m;
            I_trigger_enable = tbl[i].en;
        end
        I_match = 1'b0;

        // REQ-037: zero-width first pulse
        I_trigger_delay = '0;
        I_trigger_width = '0;
        I_num_triggers  = 4'd2;
        set_pulse(0, 1, 0);
        set_pulse(1, 1, 2);
        run_seq(10, hc, fh, lh, mi, da);
        check("w0 high count", hc, 2);
        check("w0 first high", fh, 3);
        check("w0 last high", lh, 4);
        check("w0 max index", mi, 1);
        check("w0 done cycle", da, 5);

        // Zero pulses requested: straight to DONE
        I_num_triggers = 4'd0;
        run_seq(3, hc, fh, lh, mi, da);
        check("num0 high count", hc, 0);
        check("num0 done cycle", da, 1);

        // Count above pulse capacity is clamped to 8
        I_num_triggers = 4'd15;
        for (int i = 0; i < int'(NP); i++) set_pulse(i, 0, 1);
        run_seq(14, hc, fh, lh, mi, da);
        check("clamp high count", hc, 8);
        check("clamp first high", fh, 1);
        check("clamp max index", mi, 7);
        check("clamp done cycle", da, 9);

        // REQ-038: 300 matches during a long delay, then abort in DELAY
        I_trigger_delay = '0;
        I_trigger_width = '0;
        I_num_triggers  = 4'd1;
        set_pulse(0, 400, 1);
        tick();
        I_match = 1'b1;
        repeat (300) tick();
        tick();
        I_match = 1'b0;
        check("missed saturate", 32'(O_missed_count), MISS_EN ? 32'd255 : 32'd0);
        check("long delay busy", 32'(O_busy), 1);
        I_trigger_enable = 1'b0;
        tick();
        check("abort delay busy", 32'(O_busy), 0);
        check("abort delay done", 32'(O_done), 0);
        I_trigger_enable = 1'b1;

        // REQ-039: enable dropped during PULSE
        set_pulse(0, 2, 5);
        tick();
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        tick();
        tick();
        check("abort pulse c3 trigger", 32'(O_trigger), 1);
        tick();
        check("abort pulse c4 trigger", 32'(O_trigger), 1);
        I_trigger_enable = 1'b0;
        tick();
        check("abort pulse trigger", 32'(O_trigger), 0);
        check("abort pulse busy", 32'(O_busy), 0);
        check("abort pulse done", 32'(O_done), 0);
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (O_done || O_trigger) dcnt++;
        end
        check("abort pulse later activity", dcnt, 0);
        I_trigger_enable = 1'b1;

        // REQ-040: asynchronous reset mid-DELAY
        set_pulse(0, 10, 1);
        tick();
        I_match = 1'b1;
        tick();
        I_match = 1'b0;
        tick();
        tick();
        check("pre-reset busy", 32'(O_busy), 1);
        #3 reset_n = 1'b0;
        #1;
        check("async reset trigger", 32'(O_trigger), 0);
        check("async reset busy", 32'(O_busy), 0);
        check("async reset done", 32'(O_done), 0);
        check("async reset index", 32'(O_pulse_index), 0);
        check("async reset missed", 32'(O_missed_count), 0);
        tick();
        reset_n = 1'b1;
        dcnt = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (O_done || O_busy) dcnt++;
        end
        check("post-reset activity", dcnt, 0);
        set_pulse(0, 0, 1);
        run_seq(4, hc, fh, lh, mi, da);
        check("restart first high", fh, 1);
        check("restart high count", hc, 1);
        check("restart max index", mi, 0);
        check("restart done cycle", da, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
